alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
// - RV32I execute-stage datapath: ALU-control decode and 32-bit ALU merged into one registered block.
// - Decodes opcode plus {instr[30], funct3} into a 7-bit ALU control word.
// - Computes the 32-bit result and the branch-taken flag.
// - Sits between the ID/EX pipeline register and the EX/MEM stage.
// PARAMETERS
// - none (datapath fixed at 32 bits; shift amount is b[4:0])
// PORTS
// - clk            in   1   system clock; all state updates on posedge
// - rst_n          in   1   reset, synchronous, active-low
// - opcode         in   7   instr[6:0]
// - func_code      in   4   {instr[30], instr[14:12]}
// - a              in   32  operand A (rs1 / zimm)
// - b              in   32  operand B (rs2 / imm / CSR value)
// - alu_ctl        out  7   registered decoded control word
// - alu_out        out  32  registered result
// - branch_enable  out  1   registered branch-taken flag
// BEHAVIOUR
// - Latency 1: inputs sampled at posedge N; alu_ctl, alu_out and branch_enable valid after posedge N.
// - No handshake; a new operation is accepted every cycle.
// - Reset: on posedge with rst_n=0, all three outputs become 0. Any in-flight result is discarded.
// - alu_ctl codes (hex): 00 ADD, 01 SUB, 02 AND, 03 OR, 04 XOR, 05 SLL, 06 SRL, 07 SRA,
//   08 SLT, 09 SLTU, 0A PASSA, 0B PASSB, 0C ANDN (b & ~a),
//   10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU, 7F NOP.
// - Decode, opcode 0110011 (R-type), by f3 = func_code[2:0]:
//   - 000: SUB if func_code[3]=1, else ADD.
//   - 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
//   - 101: SRA if func_code[3]=1, else SRL.
// - Decode, opcode 0010011 (I-type): same as R-type, except f3=000 is always ADD (bit 3 ignored).
// - Decode, opcode 1100011 (branch), by f3:
//   - 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
//   - 010 or 011: NOP.
// - Decode, opcode 1110011 (system), by f3[1:0]:
//   - 01 PASSA (CSRRW/I), 10 OR (CSRRS/I), 11 ANDN (CSRRC/I).
//   - 00: NOP.
// - Decode, other opcodes:
//   - 0110111 LUI: PASSB.
//   - 0000011, 0100011, 0010111, 1101111, 1100111: ADD.
//   - All other opcodes (including 0000000): NOP.
// - Arithmetic:
//   - ADD/SUB are modulo 2^32 with no carry or overflow output.
//   - SLT compares signed and SLTU unsigned; result is 32'd1 or 32'd0.
//   - Shift amount is b[4:0]; b[31:5] is ignored. SRA replicates a[31].
// - Branch ops:
//   - alu_out = a - b.
//   - branch_enable per condition: EQ, NE, signed LT/GE, unsigned LTU/GEU.
// - Non-branch ops: branch_enable = 0.
// - NOP: alu_out = 0, branch_enable = 0.
// - Fully synchronous: no combinational path from any input to any output.
// TESTING
// - Reset: rst_n=0 for 2 cycles with random inputs -> alu_ctl=0, alu_out=0, branch_enable=0;
//   then rst_n=1 -> next posedge shows the live result.
// - R-type ops (each row: a, b, func_code -> alu_out):
//   - AND: 0x0F, 0x55, 0111 -> 0x05.
//   - OR: 0x0F, 0x55, 0110 -> 0x5F.
//   - ADD: 10000, 111, 0000 -> 10111.
//   - SUB: 10000, 111, 1000 -> 9889.
//   - XOR: 0x55, 0xFF, 0100 -> 0xAA.
// - Shifts (each row: a, b, func_code -> alu_out):
//   - SRL: 0x10, 2, 0101 -> 0x4.
//   - SRA: 0x8, 1, 1101 -> 0x4.
//   - SRA: 0xFFFFFFFF, 2, 1101 -> 0xFFFFFFFF.
//   - SLL: 2, 2, 0001 -> 0x8.
//   - SLL: 2, 16, 0001 -> 0x20000.
//   - SLL: 1, 31, 0001 -> 0x80000000.
// - Compare (func_code 0010):
//   - SLT a=0, b=2 -> 1.
//   - SLT a=2, b=0 -> 0.
//   - SLT a=0xFFFFFFFF, b=1 -> 1.
//   - SLTU (0011) a=0xFFFFFFFF, b=1 -> 0.
// - Branch (opcode 1100011):
//   - BLT a=1, b=2, func_code 0100 -> branch_enable=1, alu_out=0xFFFFFFFF.
//   - BEQ a=5, b=6, func_code 0000 -> branch_enable=0.
//   - BGEU a=0xFFFFFFFF, b=1, func_code 0111 -> branch_enable=1.
// - CSR and default decode:
//   - opcode 1110011, func_code 0110, a=0x0F, b=0x55 -> alu_out=0x5F.
//   - opcode 0000000 -> alu_ctl=7F, alu_out=0, branch_enable=0.

Source files
------------

// File: rtl/alu_exec_unit.sv
// RV32I execute stage: ALU-control decode and 32-bit ALU, with one register stage on all outputs.
// The control word, result and branch flag all come from the same cycle's inputs.
module alu_exec_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [3:0]  func_code,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [6:0]  alu_ctl,
  output logic [31:0] alu_out,
  output logic        branch_enable
);

  typedef enum logic [6:0] {
    OP_ADD   = 7'h00,
    OP_SUB   = 7'h01,
    OP_AND   = 7'h02,
    OP_OR    = 7'h03,
    OP_XOR   = 7'h04,
    OP_SLL   = 7'h05,
    OP_SRL   = 7'h06,
    OP_SRA   = 7'h07,
    OP_SLT   = 7'h08,
    OP_SLTU  = 7'h09,
    OP_PASSA = 7'h0A,
    OP_PASSB = 7'h0B,
    OP_ANDN  = 7'h0C,
    OP_BEQ   = 7'h10,
    OP_BNE   = 7'h11,
    OP_BLT   = 7'h12,
    OP_BGE   = 7'h13,
    OP_BLTU  = 7'h14,
    OP_BGEU  = 7'h15,
    OP_NOP   = 7'h7F
  } alu_op_e;

  alu_op_e     alu_ctl_d, alu_ctl_q;
  logic [31:0] alu_out_d, alu_out_q;
  logic        branch_enable_d, branch_enable_q;

  logic [2:0]  f3;
  logic        alt;
  logic [31:0] diff;
  logic        eq, lt_s, lt_u;

  assign f3   = func_code[2:0];
  assign alt  = func_code[3];
  assign diff = a - b;
  assign eq   = (a == b);
  assign lt_s = ($signed(a) < $signed(b));
  assign lt_u = (a < b);

  always_comb begin
    alu_ctl_d = OP_NOP;
    case (opcode)
      7'b0110011, 7'b0010011: begin
        case (f3)
          // Immediate ADDI has no subtract form, so instr[30] only selects SUB for R-type.
          3'b000:  alu_ctl_d = (alt && (opcode == 7'b0110011)) ? OP_SUB : OP_ADD;
          3'b001:  alu_ctl_d = OP_SLL;
          3'b010:  alu_ctl_d = OP_SLT;
          3'b011:  alu_ctl_d = OP_SLTU;
          3'b100:  alu_ctl_d = OP_XOR;
          3'b101:  alu_ctl_d = alt ? OP_SRA : OP_SRL;
          3'b110:  alu_ctl_d = OP_OR;
          default: alu_ctl_d = OP_AND;
        endcase
      end
      7'b1100011: begin
        case (f3)
          3'b000:  alu_ctl_d = OP_BEQ;
          3'b001:  alu_ctl_d = OP_BNE;
          3'b100:  alu_ctl_d = OP_BLT;
          3'b101:  alu_ctl_d = OP_BGE;
          3'b110:  alu_ctl_d = OP_BLTU;
          3'b111:  alu_ctl_d = OP_BGEU;
          default: alu_ctl_d = OP_NOP;
        endcase
      end
      7'b1110011: begin
        case (f3[1:0])
          2'b01:   alu_ctl_d = OP_PASSA;
          2'b10:   alu_ctl_d = OP_OR;
          2'b11:   alu_ctl_d = OP_ANDN;
          default: alu_ctl_d = OP_NOP;
        endcase
      end
      7'b0110111: alu_ctl_d = OP_PASSB;
      7'b0000011, 7'b0100011, 7'b0010111, 7'b1101111, 7'b1100111: alu_ctl_d = OP_ADD;
      default: alu_ctl_d = OP_NOP;
    endcase
  end

  // Branches reuse the subtractor result as alu_out and only differ in the flag.
  always_comb begin
    alu_out_d       = '0;
    branch_enable_d = 1'b0;
    case (alu_ctl_d)
      OP_ADD:   alu_out_d = a + b;
      OP_SUB:   alu_out_d = diff;
      OP_AND:   alu_out_d = a & b;
      OP_OR:    alu_out_d = a | b;
      OP_XOR:   alu_out_d = a ^ b;
      OP_SLL:   alu_out_d = a << b[4:0];
      OP_SRL:   alu_out_d = a >> b[4:0];
      OP_SRA:   alu_out_d = $signed(a) >>> b[4:0];
      OP_SLT:   alu_out_d = {31'd0, lt_s};
      OP_SLTU:  alu_out_d = {31'd0, lt_u};
      OP_PASSA: alu_out_d = a;
      OP_PASSB: alu_out_d = b;
      OP_ANDN:  alu_out_d = b & ~a;
      OP_BEQ:   begin alu_out_d = diff; branch_enable_d = eq;    end
      OP_BNE:   begin alu_out_d = diff; branch_enable_d = !eq;   end
      OP_BLT:   begin alu_out_d = diff; branch_enable_d = lt_s;  end
      OP_BGE:   begin alu_out_d = diff; branch_enable_d = !lt_s; end
      OP_BLTU:  begin alu_out_d = diff; branch_enable_d = lt_u;  end
      OP_BGEU:  begin alu_out_d = diff; branch_enable_d = !lt_u; end
      default:  begin alu_out_d = '0;   branch_enable_d = 1'b0;  end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_ctl_q       <= OP_ADD;
      alu_out_q       <= '0;
      branch_enable_q <= 1'b0;
    end else begin
      alu_ctl_q       <= alu_ctl_d;
      alu_out_q       <= alu_out_d;
      branch_enable_q <= branch_enable_d;
    end
  end

  assign alu_ctl       = alu_ctl_q;
  assign alu_out       = alu_out_q;
  assign branch_enable = branch_enable_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit; each task drives one feature and checks the
// registered outputs one cycle later against hand-computed values.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [3:0]  func_code;
  logic [31:0] a;
  logic [31:0] b;
  logic [6:0]  alu_ctl;
  logic [31:0] alu_out;
  logic        branch_enable;

  int test_count = 0;
  int fail_count = 0;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [3:0]  fc;
    logic [31:0] av;
    logic [31:0] bv;
    logic [31:0] exp_out;
    logic [6:0]  exp_ctl;
    logic        exp_be;
  } vec_t;

  localparam logic [6:0] R_OP   = 7'b0110011;
  localparam logic [6:0] I_OP   = 7'b0010011;
  localparam logic [6:0] BR_OP  = 7'b1100011;
  localparam logic [6:0] SYS_OP = 7'b1110011;

  alu_exec_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .func_code     (func_code),
    .a             (a),
    .b             (b),
    .alu_ctl       (alu_ctl),
    .alu_out       (alu_out),
    .branch_enable (branch_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, then sample just after the capturing rising edge.
  task automatic apply_op(input logic [6:0] op, input logic [3:0] fc,
                          input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    opcode    = op;
    func_code = fc;
    a         = av;
    b         = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    apply_op(v.op, v.fc, v.av, v.bv);
    test_count++;
    if (alu_out !== v.exp_out) begin
      $display("[TB] FAIL %s alu_out: got %h expected %h", v.name, alu_out, v.exp_out);
      fail_count++;
    end
    test_count++;
    if (alu_ctl !== v.exp_ctl) begin
      $display("[TB] FAIL %s alu_ctl: got %h expected %h", v.name, alu_ctl, v.exp_ctl);
      fail_count++;
    end
    test_count++;
    if (branch_enable !== v.exp_be) begin
      $display("[TB] FAIL %s branch_enable: got %b expected %b", v.name, branch_enable, v.exp_be);
      fail_count++;
    end
  endtask

  task automatic test_reset;
    vec_t v;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      opcode    = 7'($urandom);
      func_code = 4'($urandom);
      a         = $urandom;
      b         = $urandom;
      @(posedge clk);
      #1;
      test_count++;
      if (alu_ctl !== 7'h00 || alu_out !== 32'h0 || branch_enable !== 1'b0) begin
        $display("[TB] FAIL reset_%0d: got ctl=%h out=%h be=%b expected 00 00000000 0",
                 i, alu_ctl, alu_out, branch_enable);
        fail_count++;
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    v = '{"reset_release_add", R_OP, 4'b0000, 32'd3, 32'd4, 32'd7, 7'h00, 1'b0};
    run_vec(v);
  endtask

  task automatic test_rtype;
    vec_t v[5];
    v[0] = '{"and", R_OP, 4'b0111, 32'h0F, 32'h55, 32'h05, 7'h02, 1'b0};
    v[1] = '{"or",  R_OP, 4'b0110, 32'h0F, 32'h55, 32'h5F, 7'h03, 1'b0};
    v[2] = '{"add", R_OP, 4'b0000, 32'd10000, 32'd111, 32'd10111, 7'h00, 1'b0};
    v[3] = '{"sub", R_OP, 4'b1000, 32'd10000, 32'd111, 32'd9889, 7'h01, 1'b0};
    v[4] = '{"xor", R_OP, 4'b0100, 32'h55, 32'hFF, 32'hAA, 7'h04, 1'b0};
    for (int i = 0; i < 5; i++) run_vec(v[i]);
  endtask

  task automatic test_shifts;
    vec_t v[9];
    v[0] = '{"srl",        R_OP, 4'b0101, 32'h10, 32'd2, 32'h4, 7'h06, 1'b0};
    v[1] = '{"sra_pos",    R_OP, 4'b1101, 32'h8, 32'd1, 32'h4, 7'h07, 1'b0};
    v[2] = '{"sra_neg",    R_OP, 4'b1101, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 7'h07, 1'b0};
    v[3] = '{"sll_2",      R_OP, 4'b0001, 32'd2, 32'd2, 32'h8, 7'h05, 1'b0};
    v[4] = '{"sll_16",     R_OP, 4'b0001, 32'd2, 32'd16, 32'h20000, 7'h05, 1'b0};
    v[5] = '{"sll_31",     R_OP, 4'b0001, 32'd1, 32'd31, 32'h80000000, 7'h05, 1'b0};
    v[6] = '{"sll_hi_ign", R_OP, 4'b0001, 32'd1, 32'h21, 32'h2, 7'h05, 1'b0};
    v[7] = '{"sra_31",     R_OP, 4'b1101, 32'h80000000, 32'd31, 32'hFFFFFFFF, 7'h07, 1'b0};
    v[8] = '{"srai",       I_OP, 4'b1101, 32'h80000000, 32'd4, 32'hF8000000, 7'h07, 1'b0};
    for (int i = 0; i < 9; i++) run_vec(v[i]);
  endtask

  task automatic test_compare;
    vec_t v[5];
    v[0] = '{"slt_0_2",    R_OP, 4'b0010, 32'd0, 32'd2, 32'd1, 7'h08, 1'b0};
    v[1] = '{"slt_2_0",    R_OP, 4'b0010, 32'd2, 32'd0, 32'd0, 7'h08, 1'b0};
    v[2] = '{"slt_neg",    R_OP, 4'b0010, 32'hFFFFFFFF, 32'd1, 32'd1, 7'h08, 1'b0};
    v[3] = '{"sltu_big",   R_OP, 4'b0011, 32'hFFFFFFFF, 32'd1, 32'd0, 7'h09, 1'b0};
    v[4] = '{"sltiu_small", I_OP, 4'b0011, 32'd1, 32'hFFFFFFFF, 32'd1, 7'h09, 1'b0};
    for (int i = 0; i < 5; i++) run_vec(v[i]);
  endtask

  task automatic test_branch;
    vec_t v[7];
    v[0] = '{"blt_taken",  BR_OP, 4'b0100, 32'd1, 32'd2, 32'hFFFFFFFF, 7'h12, 1'b1};
    v[1] = '{"beq_not",    BR_OP, 4'b0000, 32'd5, 32'd6, 32'hFFFFFFFF, 7'h10, 1'b0};
    v[2] = '{"bgeu_taken", BR_OP, 4'b0111, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFE, 7'h15, 1'b1};
    v[3] = '{"bne_not",    BR_OP, 4'b0001, 32'd5, 32'd5, 32'd0, 7'h11, 1'b0};
    v[4] = '{"bge_not",    BR_OP, 4'b0101, 32'h80000000, 32'd1, 32'h7FFFFFFF, 7'h13, 1'b0};
    v[5] = '{"bltu_taken", BR_OP, 4'b0110, 32'd1, 32'd2, 32'hFFFFFFFF, 7'h14, 1'b1};
    v[6] = '{"br_f3_010",  BR_OP, 4'b0010, 32'd1, 32'd2, 32'd0, 7'h7F, 1'b0};
    for (int i = 0; i < 7; i++) run_vec(v[i]);
  endtask

  task automatic test_csr_default;
    vec_t v[8];
    v[0] = '{"csrrs",      SYS_OP, 4'b0110, 32'h0F, 32'h55, 32'h5F, 7'h03, 1'b0};
    v[1] = '{"csrrw",      SYS_OP, 4'b0001, 32'h1234, 32'h55, 32'h1234, 7'h0A, 1'b0};
    v[2] = '{"csrrc",      SYS_OP, 4'b0011, 32'h0F, 32'h55, 32'h50, 7'h0C, 1'b0};
    v[3] = '{"sys_nop",    SYS_OP, 4'b0000, 32'h0F, 32'h55, 32'h0, 7'h7F, 1'b0};
    v[4] = '{"opc_zero",   7'b0000000, 4'b0000, 32'h0F, 32'h55, 32'h0, 7'h7F, 1'b0};
    v[5] = '{"lui",        7'b0110111, 4'b0000, 32'h1, 32'hABCDE000, 32'hABCDE000, 7'h0B, 1'b0};
    v[6] = '{"load_add",   7'b0000011, 4'b0010, 32'd100, 32'd4, 32'd104, 7'h00, 1'b0};
    v[7] = '{"addi_bit3",  I_OP, 4'b1000, 32'd10, 32'd3, 32'd13, 7'h00, 1'b0};
    for (int i = 0; i < 8; i++) run_vec(v[i]);
  endtask

  task automatic test_back_to_back;
    vec_t v;
    v = '{"b2b_add", R_OP, 4'b0000, 32'hFFFFFFFF, 32'd1, 32'd0, 7'h00, 1'b0};
    run_vec(v);
    v = '{"b2b_beq", BR_OP, 4'b0000, 32'd7, 32'd7, 32'd0, 7'h10, 1'b1};
    run_vec(v);
    // Reset while an operation is presented: the result must be discarded.
    @(negedge clk);
    rst_n     = 1'b0;
    opcode    = BR_OP;
    func_code = 4'b0100;
    a         = 32'd1;
    b         = 32'd9;
    @(posedge clk);
    #1;
    test_count++;
    if (alu_ctl !== 7'h00 || alu_out !== 32'h0 || branch_enable !== 1'b0) begin
      $display("[TB] FAIL midflight_reset: got ctl=%h out=%h be=%b expected 00 00000000 0",
               alu_ctl, alu_out, branch_enable);
      fail_count++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    v = '{"b2b_after_rst", R_OP, 4'b1000, 32'd0, 32'd1, 32'hFFFFFFFF, 7'h01, 1'b0};
    run_vec(v);
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = '0;
    func_code = '0;
    a         = '0;
    b         = '0;
    test_reset();
    test_rtype();
    test_shifts();
    test_compare();
    test_branch();
    test_csr_default();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
